// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states and default sizes.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    localparam int DEFAULT_XLEN       = 32;
    localparam int DEFAULT_IMEM_DEPTH = 128;

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
module fetch_imem
    import fetch_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
    input  logic                          clock,
    input  logic                          we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]               wdata,
    input  logic [$clog2(IMEM_DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]               rdata
);

    logic [XLEN-1:0] mem [IMEM_DEPTH];

    // No reset on the array: contents survive reset and are only set by preload writes.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks pc through imem, fills IF_ID, honours stalls and redirects,
// and parks in HALT when pc runs off the end of memory or a redirect leaves it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
    parameter int RESET_PC   = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    input  logic                          branch_taken,
    input  logic [XLEN-1:0]               branch_target,
    input  logic                          id_ready,
    output logic [2*XLEN-1:0]             IF_ID,
    output logic                          if_id_valid,
    output logic [XLEN-1:0]               pc,
    output logic                          halted
);

    localparam int              AW      = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] DEPTH_X = XLEN'(IMEM_DEPTH);
    localparam logic [XLEN-1:0] LAST_X  = DEPTH_X - XLEN'(1);

    fetch_state_t      state, state_n;
    logic [XLEN-1:0]   pc_n;
    logic [2*XLEN-1:0] if_id_n;
    logic              valid_n;
    logic              fire;
    logic [XLEN-1:0]   instr;

    fetch_imem #(
        .XLEN       (XLEN),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clock (clock),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc[AW-1:0]),
        .rdata (instr)
    );

    assign fire = !if_id_valid || id_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= XLEN'(RESET_PC);
            IF_ID       <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            IF_ID       <= if_id_n;
            if_id_valid <= valid_n;
            halted      <= (state_n == HALT);
        end
    end

    // A redirect beats both fire and stall; in HALT only the drain of IF_ID continues.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        if_id_n = IF_ID;
        valid_n = if_id_valid;
        if (branch_taken) begin
            pc_n    = branch_target;
            valid_n = 1'b0;
            state_n = (branch_target >= DEPTH_X) ? HALT : FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (fire) begin
                        if_id_n = {pc, instr};
                        valid_n = 1'b1;
                        pc_n    = pc + XLEN'(1);
                        if (pc == LAST_X) begin
                            state_n = HALT;
                        end
                    end
                end
                HALT: begin
                    if (if_id_valid && id_ready) begin
                        valid_n = 1'b0;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stalls, redirects, end-of-memory halt,
// out-of-range halt, reset during stall and same-cycle imem write collision.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic [63:0] IF_ID;
    logic        if_id_valid;
    logic [31:0] pc;
    logic        halted;

    logic [31:0] model_mem [128];
    logic [33:0] st;
    int          checks   = 0;
    int          failures = 0;

    assign st = {if_id_valid, halted, pc};

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_ready      (id_ready),
        .IF_ID         (IF_ID),
        .if_id_valid   (if_id_valid),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (i < 6) model_mem[i] = 32'h0AAA_AAAA + 32'h0111_1111 * i;
            else       model_mem[i] = 32'h5000_0000 | i;
            imem_we    = 1'b1;
            imem_waddr = 7'(i);
            imem_wdata = model_mem[i];
            tick();
        end
        imem_we = 1'b0;
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("[TB] FAIL reset_status got %h want %h", st, {1'b0, 1'b0, 32'd0});
        end
        checks++;
        if (IF_ID !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_if_id got %h want %h", IF_ID, 64'd0);
        end
    endtask

    task automatic test_sequential();
        reset    = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (IF_ID !== {32'(i), model_mem[i]}) begin
                failures++;
                $display("[TB] FAIL seq%0d_if_id got %h want %h", i, IF_ID, {32'(i), model_mem[i]});
            end
            checks++;
            if (st !== {1'b1, 1'b0, 32'(i + 1)}) begin
                failures++;
                $display("[TB] FAIL seq%0d_status got %h want %h", i, st, {1'b1, 1'b0, 32'(i + 1)});
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({IF_ID, st} !== {32'd2, 32'h0CCC_CCCC, 1'b1, 1'b0, 32'd3}) begin
                failures++;
                $display("[TB] FAIL stall%0d got %h want %h", i, {IF_ID, st},
                         {32'd2, 32'h0CCC_CCCC, 1'b1, 1'b0, 32'd3});
            end
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd3, 32'h0DDD_DDDD, 1'b1, 1'b0, 32'd4}) begin
            failures++;
            $display("[TB] FAIL stall_release got %h want %h", {IF_ID, st},
                     {32'd3, 32'h0DDD_DDDD, 1'b1, 1'b0, 32'd4});
        end
    endtask

    task automatic test_branch();
        branch_taken  = 1'b1;
        branch_target = 32'd20;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (st !== {1'b0, 1'b0, 32'd20}) begin
            failures++;
            $display("[TB] FAIL branch_bubble got %h want %h", st, {1'b0, 1'b0, 32'd20});
        end
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd20, model_mem[20], 1'b1, 1'b0, 32'd21}) begin
            failures++;
            $display("[TB] FAIL branch_target_fetch got %h want %h", {IF_ID, st},
                     {32'd20, model_mem[20], 1'b1, 1'b0, 32'd21});
        end
        id_ready      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'd30;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (st !== {1'b0, 1'b0, 32'd30}) begin
            failures++;
            $display("[TB] FAIL branch_stalled_bubble got %h want %h", st, {1'b0, 1'b0, 32'd30});
        end
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd30, model_mem[30], 1'b1, 1'b0, 32'd31}) begin
            failures++;
            $display("[TB] FAIL branch_stalled_fetch got %h want %h", {IF_ID, st},
                     {32'd30, model_mem[30], 1'b1, 1'b0, 32'd31});
        end
        id_ready = 1'b1;
    endtask

    task automatic test_halt_end();
        branch_taken  = 1'b1;
        branch_target = 32'd125;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd127, model_mem[127], 1'b1, 1'b1, 32'd128}) begin
            failures++;
            $display("[TB] FAIL end_last_issue got %h want %h", {IF_ID, st},
                     {32'd127, model_mem[127], 1'b1, 1'b1, 32'd128});
        end
        id_ready = 1'b0;
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd127, model_mem[127], 1'b1, 1'b1, 32'd128}) begin
            failures++;
            $display("[TB] FAIL halt_hold_valid got %h want %h", {IF_ID, st},
                     {32'd127, model_mem[127], 1'b1, 1'b1, 32'd128});
        end
        id_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (st !== {1'b0, 1'b1, 32'd128}) begin
                failures++;
                $display("[TB] FAIL halt_idle%0d got %h want %h", i, st, {1'b0, 1'b1, 32'd128});
            end
        end
        branch_taken  = 1'b1;
        branch_target = 32'd0;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (st !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("[TB] FAIL halt_resume got %h want %h", st, {1'b0, 1'b0, 32'd0});
        end
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd0, model_mem[0], 1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("[TB] FAIL halt_resume_fetch got %h want %h", {IF_ID, st},
                     {32'd0, model_mem[0], 1'b1, 1'b0, 32'd1});
        end
    endtask

    task automatic test_out_of_range();
        branch_taken  = 1'b1;
        branch_target = 32'd200;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (st !== {1'b0, 1'b1, 32'd200}) begin
            failures++;
            $display("[TB] FAIL oor_halt got %h want %h", st, {1'b0, 1'b1, 32'd200});
        end
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 32'd200}) begin
            failures++;
            $display("[TB] FAIL oor_hold got %h want %h", st, {1'b0, 1'b1, 32'd200});
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (st !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("[TB] FAIL oor_reset got %h want %h", st, {1'b0, 1'b0, 32'd0});
        end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        tick();
        id_ready = 1'b0;
        tick();
        checks++;
        if ({IF_ID, st} !== {32'd1, model_mem[1], 1'b1, 1'b0, 32'd2}) begin
            failures++;
            $display("[TB] FAIL pre_reset_stall got %h want %h", {IF_ID, st},
                     {32'd1, model_mem[1], 1'b1, 1'b0, 32'd2});
        end
        reset         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'd200;
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({IF_ID, st} !== {64'd0, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("[TB] FAIL reset_mid_stall got %h want %h", {IF_ID, st},
                     {64'd0, 1'b0, 1'b0, 32'd0});
        end
    endtask

    task automatic test_rw_collision();
        reset      = 1'b1;
        id_ready   = 1'b1;
        imem_we    = 1'b1;
        imem_waddr = 7'd0;
        imem_wdata = 32'h1234_5678;
        tick();
        imem_we = 1'b0;
        checks++;
        if (IF_ID !== {32'd0, model_mem[0]}) begin
            failures++;
            $display("[TB] FAIL collision_old got %h want %h", IF_ID, {32'd0, model_mem[0]});
        end
        model_mem[0]  = 32'h1234_5678;
        branch_taken  = 1'b1;
        branch_target = 32'd0;
        tick();
        branch_taken = 1'b0;
        tick();
        checks++;
        if (IF_ID !== {32'd0, model_mem[0]}) begin
            failures++;
            $display("[TB] FAIL collision_new got %h want %h", IF_ID, {32'd0, model_mem[0]});
        end
    endtask

    initial begin
        reset         = 1'b0;
        imem_we       = 1'b0;
        imem_waddr    = '0;
        imem_wdata    = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        id_ready      = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt_end();
        test_out_of_range();
        test_reset_mid_stall();
        test_rw_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
